div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider serving DIV/DIVU issued from the execute stage.
//  The execute stage initiates; this block responds with a stall request while busy.
//  It then returns quotient (LO) and remainder (HI) for the hilo write path.
//  Sits beside the ALU; its ready/stall outputs feed the hazard unit.
// PARAMETERS
//  WIDTH  32  operand / result width (quotient and remainder each WIDTH bits)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-high reset
//  start      in   1      divide request, held by execute stage while div_stall=1
//  signed_div in   1      1=DIV (two's complement), 0=DIVU; sampled with start in IDLE
//  annul      in   1      execute-stage flush; aborts operation in progress
//  opa        in   WIDTH  dividend (rs), sampled in IDLE when start=1
//  opb        in   WIDTH  divisor (rt), sampled in IDLE when start=1
//  div_stall  out  1      combinational stall request to hazard unit
//  ready      out  1      1-cycle pulse: hi_out/lo_out valid
//  hi_out     out  WIDTH  remainder (registered)
//  lo_out     out  WIDTH  quotient (registered)
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, ready=0, hi_out=0, lo_out=0; div_stall=0 while start=0.
//  - States: IDLE, RUN, DZERO, DONE.
//  - IDLE: start&~annul -> latch |opa|,|opb|, quotient sign (sa^sb), remainder sign (sa).
//    -> DZERO if opb==0, else RUN with counter=0.
//  - RUN: one restoring step per cycle, MSB first: shift {rem,quo} left 1;
//    if rem>=divisor then rem-=divisor and quo[0]=1.
//    Counter wraps at WIDTH-1; -> DONE after exactly WIDTH RUN cycles.
//  - DONE: apply signs (negate quo if qsign, rem if rsign), register into lo_out/hi_out.
//    Assert ready=1 for this one cycle; -> IDLE next cycle.
//  - DZERO: lo_out=all ones, hi_out=opa (as sampled, unmodified); ready=1 one cycle; -> IDLE.
//  - div_stall = (IDLE & start & ~annul) | RUN | (DZERO? 0) ; div_stall=0 in DONE/DZERO.
//    Pipeline advances on the ready cycle and captures hi_out/lo_out then.
//  - Latency: start seen in IDLE at cycle 0 -> ready at cycle WIDTH+1 (33); stall cycles 0..32.
//    Divide by zero: ready at cycle 1, stall in cycle 0 only.
//  - start in DONE/DZERO is ignored (belongs to the retiring instruction);
//    a new start is accepted only in IDLE.
//  - annul in IDLE: request not accepted, div_stall=0.
//    annul in RUN: -> IDLE next cycle; no ready; hi_out/lo_out unchanged.
//  - annul in DONE/DZERO: ready still pulses; outputs update (hilo write is suppressed
//    downstream by the flushed hilowrite control).
//  - Overflow 0x80000000 / -1 (signed): lo_out=0x80000000, hi_out=0; no exception.
//  - Signed results follow truncation toward zero: remainder sign = dividend sign.
//  - hi_out/lo_out hold their last value until the next ready; never change while stalled.
//  - rst asserted in any state: IDLE next cycle, outputs cleared, no ready pulse.
// TESTING
//  - DIVU 100/7: start cycle 0 -> div_stall 0..32, ready@33, lo=14, hi=2.
//  - DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    DIV 7/-2 -> lo=-3, hi=1.
//  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//    DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
//  - Divide by zero opa=0x1234: ready@1, lo=0xFFFFFFFF, hi=0x1234, div_stall only in cycle 0.
//  - annul at cycle 10 of RUN -> IDLE at 11, no ready, outputs keep prior result.
//    Fresh start at 12 completes at 45.
//  - Back-to-back: start held through DONE, then a new op in the next IDLE cycle.
//    Exactly one ready per op.
//    rst mid-RUN -> outputs 0, no ready.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   Operands are converted to magnitudes on acceptance, one quotient bit is
//   produced per RUN cycle (MSB first), and signs are applied as the final
//   step is written into the result registers. ready is high for the single
//   cycle the result is presented (DONE or DZERO).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, signed_div    divide request / 1=DIV, 0=DIVU (sampled in IDLE)
//   annul                execute-stage flush, aborts a RUN in progress
//   opa, opb             dividend / divisor
//   div_stall            combinational stall request to the hazard unit
//   ready                one-cycle pulse, hi_out/lo_out valid
//   hi_out, lo_out       remainder / quotient (registered)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             div_stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;

  logic             sa, sb, last;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign sa    = signed_div & opa[WIDTH-1];
  assign sb    = signed_div & opb[WIDTH-1];
  // Negating the most negative value yields itself, which read unsigned is
  // the correct magnitude 2^(WIDTH-1).
  assign abs_a = sa ? -opa : opa;
  assign abs_b = sb ? -opb : opb;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor and
  // keep the difference when it did not borrow.
  assign sh       = {rem_q, quo_q[WIDTH-1]};
  assign diff     = sh - {1'b0, dvs_q};
  assign ge       = ~diff[WIDTH];
  assign step_rem = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ge};
  assign last     = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          rem_d   = '0;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          qsign_d = sa ^ sb;
          rsign_d = sa;
          cnt_d   = '0;
          if (opb == '0) begin
            state_d = DZERO;
            lo_d    = '1;
            hi_d    = opa;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (annul) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = last ? '0 : cnt_q + CW'(1);
          if (last) begin
            // Results land in the output registers on the edge into DONE so
            // they are valid during the ready cycle.
            state_d = DONE;
            lo_d    = qsign_q ? -step_quo : step_quo;
            hi_d    = rsign_q ? -step_rem : step_rem;
          end
        end
      end
      DZERO:   state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
    end
  end

  assign div_stall = ((state_q == IDLE) && start && !annul) || (state_q == RUN);
  assign ready     = (state_q == DONE) || (state_q == DZERO);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_div, annul;
  logic [31:0] opa, opb;
  logic        div_stall, ready;
  logic [31:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;  // {hi,lo} expected to be held on the outputs

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .annul(annul), .opa(opa), .opb(opb), .div_stall(div_stall),
    .ready(ready), .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Scoreboard: every ready pops one expected result.
  always @(negedge clk) begin
    if (ready) begin
      if (sb_q.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
      else chk("result", {hi_out, lo_out}, sb_q.pop_front());
    end
  end

  // Issue one op at the next cycle (cycle 0) and follow it to its ready.
  // hold keeps start asserted through the ready cycle.
  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int lat;
    bit got;
    logic [63:0] e;
    e   = model(sg, a, b);
    lat = (b == 32'd0) ? 1 : 33;
    got = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sg; opa = a; opb = b;
    sb_q.push_back(e);
    for (int c = 0; c <= 40 && !got; c++) begin
      @(negedge clk);
      chk("stall", 64'(div_stall), 64'(c < lat));
      if (ready) begin
        got = 1'b1;
        chk("latency", 64'(c), 64'(lat));
        last_res = e;
      end else begin
        chk("hold", {hi_out, lo_out}, last_res);
      end
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opa = '0; opb = '0; last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_stall", 64'(div_stall), 64'd0);
    chk("rst_out", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(1'b0, 32'h0000_1234, 32'd0, 1'b0);
    run_op(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op(1'b0, 32'd5, 32'd9, 1'b0);

    // Annul in RUN at cycle 10: idle at 11, outputs keep prior result.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("annul_run_stall", 64'(div_stall), 64'd1);
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_idle_stall", 64'(div_stall), 64'd0);
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_hold", {hi_out, lo_out}, last_res);
    run_op(1'b0, 32'd1000, 32'd3, 1'b0);

    // Back-to-back: start stays high through DONE, next op in the IDLE cycle.
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 1'b1);
    run_op(1'b0, 32'd77, 32'd0, 1'b0);

    // Annul in IDLE: request not accepted.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; opa = 32'd50; opb = 32'd5;
    @(negedge clk);
    chk("annul_idle_req", 64'(div_stall), 64'd0);
    @(posedge clk); #1 start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk("annul_idle_after", 64'(div_stall), 64'd0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      run_op(1'($urandom_range(0, 1)), a, b, 1'b0);
    end

    // Reset mid-RUN: outputs cleared, no ready afterwards.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opa = 32'd999; opb = 32'd4;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    chk("rst_mid_out", {hi_out, lo_out}, 64'd0);
    chk("rst_mid_stall", 64'(div_stall), 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_mid_hold", {hi_out, lo_out}, 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
